// File: rtl/processor_pkg.sv
// Shared decode constants for the hazard scoreboard: instruction field
// positions, opcode / ALU-op encodings and the decoded instruction class.
package processor_pkg;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 27;
  localparam int RD_HI     = 26;
  localparam int RD_LO     = 22;
  localparam int RS1_HI    = 21;
  localparam int RS1_LO    = 17;
  localparam int RS2_HI    = 16;
  localparam int RS2_LO    = 12;
  localparam int ALUOP_HI  = 6;
  localparam int ALUOP_LO  = 2;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [2:0] {
    CLS_OTHER,
    CLS_LW,
    CLS_SW,
    CLS_MUL,
    CLS_DIV
  } insn_class_e;

  // Classify an instruction from its opcode and ALU-op fields.
  function automatic insn_class_e decode_class(input logic [4:0] opcode,
                                               input logic [4:0] alu_op);
    insn_class_e cls;
    cls = CLS_OTHER;
    if (opcode == OP_LW) begin
      cls = CLS_LW;
    end else if (opcode == OP_SW) begin
      cls = CLS_SW;
    end else if (opcode == OP_ALU && alu_op == ALU_MUL) begin
      cls = CLS_MUL;
    end else if (opcode == OP_ALU && alu_op == ALU_DIV) begin
      cls = CLS_DIV;
    end
    return cls;
  endfunction

endpackage

// File: rtl/md_dest_fifo.sv
// In-order FIFO of destination registers for outstanding mult/div ops.
// Every entry's rd and valid bit are exported in parallel so the hazard
// logic can compare decode sources against all of them at once.
module md_dest_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_rd,
  output logic                     full,
  output logic                     empty,
  output logic [CW-1:0]            count,
  output logic [PW-1:0]            rd_ptr,
  output logic [DEPTH-1:0][AW-1:0] entry_rd,
  output logic [DEPTH-1:0]         entry_valid
);

  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;
  logic                     push_en, pop_en;

  // Pointers wrap back to zero after the last slot, for any depth.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign rd_ptr      = rd_ptr_q;
  assign entry_rd    = rd_q;
  assign entry_valid = valid_q;

  // Next-state: pop clears the oldest slot first, so a same-cycle push into
  // a full FIFO (which lands on that same slot) wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    rd_d     = rd_q;
    pop_en   = pop && !empty;
    push_en  = push && (!full || pop_en);
    if (pop_en) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = next_ptr(rd_ptr_q);
    end
    if (push_en) begin
      valid_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]    = push_rd;
      wr_ptr_d          = next_ptr(wr_ptr_q);
    end
    count_d = count_q + CW'(push_en) - CW'(pop_en);
  end

  // FIFO state registers; reset overrides any same-cycle push or pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      rd_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      rd_q     <= rd_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detection: load-use, mult/div result dependency and
// mult/div structural stalls. Define SCOREBOARD_EN for per-register
// dependency tracking; without it any outstanding mult/div stalls decode.
module hazard_scoreboard
  import processor_pkg::*;
#(
  parameter int INSN_W   = 32,
  parameter int REG_AW   = 5,
  parameter int MD_DEPTH = 2,
  localparam int CW      = $clog2(MD_DEPTH) + 1,
  localparam int PW      = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INSN_W-1:0] fd_insn,
  input  logic [INSN_W-1:0] dx_insn,
  input  logic              dx_valid,
  input  logic              md_done,
  output logic              stall,
  output logic              dx_hold,
  output logic [CW-1:0]     md_count,
  output logic              md_err
);

  insn_class_e                   fd_cls, dx_cls;
  logic [2:0][REG_AW-1:0]        fd_src;
  logic [2:0]                    fd_src_en;
  logic [REG_AW-1:0]             dx_rd;
  logic                          load_use, md_issue, md_accept, structural, md_hit;
  logic                          fifo_full, fifo_empty, fifo_pop;
  logic [PW-1:0]                 fifo_rd_ptr;
  logic [MD_DEPTH-1:0][REG_AW-1:0] entry_rd;
  logic [MD_DEPTH-1:0]           entry_valid;
  logic                          md_err_q, md_err_d;
  logic                          unused_insn_bits;

  assign unused_insn_bits = ^{fd_insn, dx_insn};

  assign fd_cls = decode_class(fd_insn[OPCODE_HI:OPCODE_LO], fd_insn[ALUOP_HI:ALUOP_LO]);
  assign dx_cls = decode_class(dx_insn[OPCODE_HI:OPCODE_LO], dx_insn[ALUOP_HI:ALUOP_LO]);
  assign dx_rd  = REG_AW'(dx_insn[RD_HI:RD_LO]);

  assign fifo_pop = md_done && !fifo_empty;

  md_dest_fifo #(
    .DEPTH (MD_DEPTH),
    .AW    (REG_AW)
  ) u_md_dest_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (md_accept),
    .pop         (fifo_pop),
    .push_rd     (dx_rd),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (md_count),
    .rd_ptr      (fifo_rd_ptr),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  // Source operands of decode and the load-use / structural conditions;
  // register 0 is never a hazard.
  always_comb begin
    fd_src[0]    = REG_AW'(fd_insn[RS1_HI:RS1_LO]);
    fd_src[1]    = REG_AW'(fd_insn[RS2_HI:RS2_LO]);
    fd_src[2]    = REG_AW'(fd_insn[RD_HI:RD_LO]);
    fd_src_en[0] = (fd_src[0] != '0);
    fd_src_en[1] = (fd_src[1] != '0);
    fd_src_en[2] = (fd_src[2] != '0) && (fd_cls == CLS_SW);
    load_use     = 1'b0;
    if (dx_valid && dx_cls == CLS_LW && dx_rd != '0) begin
      for (int s = 0; s < 3; s++) begin
        if (fd_src_en[s] && fd_src[s] == dx_rd) load_use = 1'b1;
      end
    end
    md_issue   = dx_valid && (dx_cls == CLS_MUL || dx_cls == CLS_DIV);
    md_accept  = md_issue && (!fifo_full || md_done);
    structural = md_issue && !md_accept;
  end

`ifdef SCOREBOARD_EN
  // Per-register dependency: match live FIFO entries (excluding the one
  // retiring this cycle) and the mult/div currently issuing from execute.
  always_comb begin
    md_hit = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (fd_src_en[s]) begin
        if (md_issue && dx_rd == fd_src[s]) md_hit = 1'b1;
        for (int e = 0; e < MD_DEPTH; e++) begin
          if (entry_valid[e] && entry_rd[e] == fd_src[s] &&
              !(fifo_pop && fifo_rd_ptr == PW'(e))) begin
            md_hit = 1'b1;
          end
        end
      end
    end
  end
`else
  // Conservative mode: any outstanding or issuing mult/div stalls decode.
  always_comb begin
    md_hit = (md_count != '0) || md_issue;
  end
`endif

  assign stall   = !reset && (load_use || md_hit || structural);
  assign dx_hold = !reset && structural;
  assign md_err  = md_err_q;

  // Sticky error once a completion arrives with nothing outstanding.
  always_comb begin
    md_err_d = md_err_q;
    if (md_done && fifo_empty) md_err_d = 1'b1;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      md_err_q <= 1'b0;
    end else begin
      md_err_q <= md_err_d;
    end
  end

endmodule
